// File: rtl/fifo_producer_mc_pkg.sv
// fifo_producer_mc_pkg: shared types and width helpers for the multi-channel burst producer.
package fifo_producer_mc_pkg;

    // Bit positions of each state inside the one-hot state vector
    localparam int unsigned IDLE_B        = 0;
    localparam int unsigned WAIT_B        = 1;
    localparam int unsigned BURST_B       = 2;
    localparam int unsigned BURST_DONE_B  = 3;
    localparam int unsigned BURST_NDONE_B = 4;
    localparam int unsigned DONE_B        = 5;

    typedef enum logic [5:0] {
        S_IDLE        = 6'b000001,
        S_WAIT        = 6'b000010,
        S_BURST       = 6'b000100,
        S_BURST_DONE  = 6'b001000,
        S_BURST_NDONE = 6'b010000,
        S_DONE        = 6'b100000
    } fifo_producer_mc_state_t;

    // Burst-length field must be able to hold MAX_BURST itself
    function automatic int unsigned calc_bl_w(input int unsigned max_burst);
        return $clog2(max_burst + 1);
    endfunction

    // Channel index width, never narrower than one bit
    function automatic int unsigned calc_ch_w(input int unsigned num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/fifo_producer_mc_burst_ctr.sv
// fifo_producer_mc_burst_ctr: per-burst issue/receive counters and the read address pointer.
// Requests are issued until cur_len words have been granted; completion is flagged on the
// cycle the last read word of the burst arrives.
module fifo_producer_mc_burst_ctr
    import fifo_producer_mc_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned BL_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              clear,
    input  logic              active,
    input  logic [BL_W-1:0]   cur_len,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              rx_fire,
    output logic              burst_end
);

    logic [BL_W-1:0] issued_q;
    logic [BL_W-1:0] received_q;
    logic            gnt_fire;

    assign mem_req   = active && (issued_q < cur_len);
    assign gnt_fire  = mem_req && mem_gnt;
    // Read data only counts inside an active burst; stray beats elsewhere are dropped
    assign rx_fire   = active && mem_rvalid && (received_q < cur_len);
    assign burst_end = rx_fire && ((received_q + BL_W'(1)) == cur_len);

    // Issue and receive counters; a grant and a read beat may land in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            issued_q   <= '0;
            received_q <= '0;
        end else if (clear) begin
            issued_q   <= '0;
            received_q <= '0;
        end else begin
            if (gnt_fire) begin
                issued_q <= issued_q + BL_W'(1);
            end
            if (rx_fire) begin
                received_q <= received_q + BL_W'(1);
            end
        end
    end

    // Read address: loaded at start, advances per grant and wraps naturally at 2^ADDR_W
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr <= '0;
        end else if (load) begin
            mem_addr <= base_addr;
        end else if (gnt_fire) begin
            mem_addr <= mem_addr + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/fifo_producer_mc.sv
// fifo_producer_mc: reads total_len words from memory in bursts and pushes each burst into
// one of NUM_CH downstream FIFOs, either round-robin per burst or to a fixed channel.
// Optional feature: define FIFO_PRODUCER_MC_PERF_EN to add the perf_wait_cyc / perf_bursts
// counters; without it those ports and their logic do not exist.
module fifo_producer_mc
    import fifo_producer_mc_pkg::*;
#(
    parameter int unsigned  DATA_W    = 32,
    parameter int unsigned  ADDR_W    = 16,
    parameter int unsigned  LEN_W     = 16,
    parameter int unsigned  NUM_CH    = 4,
    parameter int unsigned  MAX_BURST = 16,
    localparam int unsigned BL_W      = calc_bl_w(MAX_BURST),
    localparam int unsigned CH_W      = calc_ch_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  total_len,
    input  logic [BL_W-1:0]   burst_len,
    input  logic              mode_rr,
    input  logic [CH_W-1:0]   ch_sel,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [NUM_CH-1:0] fifo_burst_ok,
    output logic [NUM_CH-1:0] fifo_push,
    output logic [DATA_W-1:0] fifo_wdata,
`ifdef FIFO_PRODUCER_MC_PERF_EN
    output logic [31:0]       perf_wait_cyc,
    output logic [15:0]       perf_bursts,
`endif
    output logic              busy,
    output logic              done
);

    localparam int unsigned     CMP_W   = (LEN_W > BL_W) ? LEN_W : BL_W;
    localparam logic [BL_W-1:0] MAX_BL  = BL_W'(MAX_BURST);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    fifo_producer_mc_state_t state_q;
    fifo_producer_mc_state_t state_d;

    logic [LEN_W-1:0] remaining_q;
    logic [BL_W-1:0]  eff_burst_q;
    logic [BL_W-1:0]  cur_len_q;
    logic [BL_W-1:0]  cur_len_calc;
    logic [CH_W-1:0]  cur_ch_q;
    logic             mode_rr_q;
    logic             start_acc;
    logic             in_burst;
    logic             rx_fire;
    logic             burst_end;
    logic             last_burst;
    logic [CMP_W-1:0] eff_wide;
    logic [CMP_W-1:0] rem_wide;

    assign start_acc = state_q[IDLE_B] && start;
    assign in_burst  = state_q[BURST_B];
    assign busy      = ~state_q[IDLE_B];

    // Next burst length is the configured burst clipped to what is left
    assign eff_wide     = CMP_W'(eff_burst_q);
    assign rem_wide     = CMP_W'(remaining_q);
    assign cur_len_calc = (eff_wide < rem_wide) ? eff_burst_q : BL_W'(remaining_q);
    assign last_burst   = (rem_wide == CMP_W'(cur_len_q));

    fifo_producer_mc_burst_ctr #(
        .ADDR_W (ADDR_W),
        .BL_W   (BL_W)
    ) u_burst_ctr (
        .clk        (clk),
        .rst        (rst),
        .load       (start_acc),
        .base_addr  (base_addr),
        .clear      (~in_burst),
        .active     (in_burst),
        .cur_len    (cur_len_q),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .rx_fire    (rx_fire),
        .burst_end  (burst_end)
    );

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (total_len == '0) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (fifo_burst_ok[cur_ch_q]) begin
                    state_d = S_BURST;
                end
            end
            S_BURST: begin
                if (burst_end) begin
                    state_d = last_burst ? S_BURST_DONE : S_BURST_NDONE;
                end
            end
            S_BURST_DONE:  state_d = S_DONE;
            S_BURST_NDONE: state_d = S_WAIT;
            S_DONE:        state_d = S_IDLE;
            default:       state_d = S_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latched configuration, remaining-word count and channel rotation
    always_ff @(posedge clk) begin
        if (rst) begin
            remaining_q <= '0;
            eff_burst_q <= '0;
            cur_len_q   <= '0;
            cur_ch_q    <= '0;
            mode_rr_q   <= 1'b0;
        end else begin
            if (start_acc) begin
                remaining_q <= total_len;
                eff_burst_q <= ((burst_len == '0) || (burst_len > MAX_BL)) ? MAX_BL : burst_len;
                mode_rr_q   <= mode_rr;
                cur_ch_q    <= ({1'b0, ch_sel} >= (CH_W + 1)'(NUM_CH)) ? '0 : ch_sel;
            end
            if (state_q[WAIT_B]) begin
                cur_len_q <= cur_len_calc;
            end
            if (burst_end) begin
                remaining_q <= remaining_q - LEN_W'(cur_len_q);
            end
            if (state_q[BURST_NDONE_B] && mode_rr_q) begin
                cur_ch_q <= (cur_ch_q == LAST_CH) ? '0 : cur_ch_q + CH_W'(1);
            end
        end
    end

    // Registered FIFO push: each accepted read beat appears one cycle later on cur_ch
    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_push  <= '0;
            fifo_wdata <= '0;
        end else begin
            fifo_push <= rx_fire ? (NUM_CH'(1) << cur_ch_q) : '0;
            if (rx_fire) begin
                fifo_wdata <= mem_rdata;
            end
        end
    end

    // Completion pulse is registered off the DONE state, so it lands as busy drops
    always_ff @(posedge clk) begin
        if (rst) begin
            done <= 1'b0;
        end else begin
            done <= state_q[DONE_B];
        end
    end

`ifdef FIFO_PRODUCER_MC_PERF_EN
    // Saturating wait-cycle and completed-burst counters, cleared on each accepted start
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_wait_cyc <= '0;
            perf_bursts   <= '0;
        end else if (start_acc) begin
            perf_wait_cyc <= '0;
            perf_bursts   <= '0;
        end else begin
            if (state_q[WAIT_B] && (perf_wait_cyc != '1)) begin
                perf_wait_cyc <= perf_wait_cyc + 32'd1;
            end
            if (burst_end && (perf_bursts != '1)) begin
                perf_bursts <= perf_bursts + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_producer_mc.sv
// tb_fifo_producer_mc: scenario tasks plus randomized transfers against a transfer-level model.
// Build with FIFO_PRODUCER_MC_PERF_EN defined to also exercise the perf counters.
module tb_fifo_producer_mc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] base_addr = '0;
    logic [15:0] total_len = '0;
    logic [4:0]  burst_len = '0;
    logic        mode_rr = 1'b0;
    logic [1:0]  ch_sel = '0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [3:0]  fifo_burst_ok;
    logic [3:0]  fifo_push;
    logic [31:0] fifo_wdata;
    logic        busy;
    logic        done;
`ifdef FIFO_PRODUCER_MC_PERF_EN
    logic [31:0] perf_wait_cyc;
    logic [15:0] perf_bursts;
`endif

    fifo_producer_mc dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .base_addr     (base_addr),
        .total_len     (total_len),
        .burst_len     (burst_len),
        .mode_rr       (mode_rr),
        .ch_sel        (ch_sel),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_gnt       (mem_gnt),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .fifo_burst_ok (fifo_burst_ok),
        .fifo_push     (fifo_push),
        .fifo_wdata    (fifo_wdata),
`ifdef FIFO_PRODUCER_MC_PERF_EN
        .perf_wait_cyc (perf_wait_cyc),
        .perf_bursts   (perf_bursts),
`endif
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass = 0;

    // Memory / FIFO environment knobs
    int   gnt_mode = 0;      // 0 always grant, 1 every other cycle, 2 random
    int   lat_cfg = 1;       // read latency in cycles; 0 = random 1..4
    bit   ok_rand = 0;
    logic [3:0] ok_fixed = 4'hF;
    bit   gnt_phase = 0;

    typedef struct { logic [15:0] addr; int due; } pend_t;
    pend_t pend[$];
    int last_due = 0;
    int m_lat, m_due, m_idx;

    // Observations
    int          got_ch[$];
    logic [31:0] got_data[$];
    logic [15:0] gnt_addr[$];
    int          first_req_cyc, done_cyc, done_cnt, start_cyc;
    logic        busy_at_done;

    // Expected transfer
    int          exp_ch[$];
    logic [31:0] exp_data[$];
    logic [15:0] exp_addr[$];
    int          exp_bursts;

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return {a ^ 16'h5A3C, a};
    endfunction

    // Transfer-level model: split into bursts, walk addresses, rotate channels
    function automatic void build_model(input logic [15:0] b, input logic [15:0] tl,
                                        input logic [4:0] bl, input logic rr,
                                        input logic [1:0] cs);
        int rem, ch, eb, n;
        logic [15:0] a;
        exp_ch.delete(); exp_data.delete(); exp_addr.delete();
        exp_bursts = 0;
        rem = int'(tl);
        ch  = int'(cs);
        eb  = (bl == 0 || bl > 16) ? 16 : int'(bl);
        a   = b;
        while (rem > 0) begin
            n = (rem < eb) ? rem : eb;
            repeat (n) begin
                exp_ch.push_back(ch);
                exp_data.push_back(mem_word(a));
                exp_addr.push_back(a);
                a = a + 16'd1;
            end
            rem = rem - n;
            exp_bursts++;
            if (rr) ch = (ch + 1) % 4;
        end
    endfunction

    // Memory responder and FIFO-ready driver, updated just after each rising edge
    initial begin
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; fifo_burst_ok = 4'hF;
        forever begin
            @(posedge clk); #1;
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                mem_rvalid = 1'b1;
                mem_rdata  = mem_word(pend[0].addr);
                void'(pend.pop_front());
            end else begin
                mem_rvalid = 1'b0;
                mem_rdata  = 32'hDEAD_BEEF;
            end
            gnt_phase = ~gnt_phase;
            case (gnt_mode)
                0:       mem_gnt = 1'b1;
                1:       mem_gnt = gnt_phase;
                default: mem_gnt = ($urandom_range(0, 1) == 1);
            endcase
            fifo_burst_ok = ok_rand ? 4'($urandom_range(0, 15) | $urandom_range(0, 15)) : ok_fixed;
        end
    end

    // Mid-cycle monitor: grants, pushes, first request, done pulses
    always @(negedge clk) begin
        if (mem_req && mem_gnt) begin
            m_lat = (lat_cfg == 0) ? int'($urandom_range(1, 4)) : lat_cfg;
            m_due = cyc + m_lat;
            if (m_due < last_due) m_due = last_due;
            last_due = m_due;
            pend.push_back('{mem_addr, m_due});
            gnt_addr.push_back(mem_addr);
        end
        if (mem_req && first_req_cyc < 0) first_req_cyc = cyc;
        if (fifo_push != 4'b0) begin
            m_idx = -1;
            if ($onehot(fifo_push)) begin
                for (int k = 0; k < 4; k++) if (fifo_push[k]) m_idx = k;
            end
            got_ch.push_back(m_idx);
            got_data.push_back(fifo_wdata);
        end
        if (done) begin
            done_cnt++;
            if (done_cyc < 0) begin
                done_cyc = cyc;
                busy_at_done = busy;
            end
        end
    end

    task automatic do_start(input logic [15:0] b, input logic [15:0] tl, input logic [4:0] bl,
                            input logic rr, input logic [1:0] cs);
        build_model(b, tl, bl, rr, cs);
        @(posedge clk); #1;
        got_ch.delete(); got_data.delete(); gnt_addr.delete();
        first_req_cyc = -1; done_cyc = -1; done_cnt = 0;
        base_addr = b; total_len = tl; burst_len = bl; mode_rr = rr; ch_sel = cs;
        start = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output bit fin);
        fin = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (done) begin
                fin = 1;
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({mem_req, mem_addr, fifo_push, fifo_wdata, busy, done} !== '0)
            $display("FAIL reset_outputs: req=%0b addr=%0h push=%0h wdata=%0h busy=%0b done=%0b, want all 0",
                     mem_req, mem_addr, fifo_push, fifo_wdata, busy, done);
        else n_pass++;
`ifdef FIFO_PRODUCER_MC_PERF_EN
        n_checks++;
        if (perf_wait_cyc !== 32'd0 || perf_bursts !== 16'd0)
            $display("FAIL reset_perf: wait=%0d bursts=%0d, want 0 0", perf_wait_cyc, perf_bursts);
        else n_pass++;
`endif
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_rr_basic();
        bit fin;
        gnt_mode = 0; lat_cfg = 1; ok_rand = 0; ok_fixed = 4'hF;
        do_start(16'h0100, 16'd40, 5'd16, 1'b1, 2'd0);
        wait_done(fin);
        n_checks++;
        if (!fin) $display("FAIL rr_done_timeout: got no done, want done"); else n_pass++;
        n_checks++;
        if (first_req_cyc - start_cyc != 2)
            $display("FAIL rr_req_latency: got %0d, want 2", first_req_cyc - start_cyc);
        else n_pass++;
        n_checks++;
        if (done_cnt != 1 || busy_at_done !== 1'b0)
            $display("FAIL rr_done_pulse: got cnt=%0d busy=%0b, want 1 0", done_cnt, busy_at_done);
        else n_pass++;
        n_checks++;
        if (got_ch.size() != exp_ch.size())
            $display("FAIL rr_count: got %0d, want %0d", got_ch.size(), exp_ch.size());
        else n_pass++;
        foreach (exp_ch[i]) begin
            n_checks++;
            if (i >= got_ch.size() || got_ch[i] != exp_ch[i] || got_data[i] !== exp_data[i])
                $display("FAIL rr_push[%0d]: got ch%0d %0h, want ch%0d %0h", i,
                         (i < got_ch.size()) ? got_ch[i] : -1,
                         (i < got_ch.size()) ? got_data[i] : 32'h0, exp_ch[i], exp_data[i]);
            else n_pass++;
        end
    endtask

    task automatic test_zero_len();
        bit fin;
        do_start(16'h0555, 16'd0, 5'd4, 1'b1, 2'd1);
        wait_done(fin);
        n_checks++;
        if (!fin || done_cyc - start_cyc != 2)
            $display("FAIL zero_done_latency: got fin=%0b dly=%0d, want 1 2", fin, done_cyc - start_cyc);
        else n_pass++;
        n_checks++;
        if (first_req_cyc != -1 || got_ch.size() != 0 || done_cnt != 1)
            $display("FAIL zero_activity: got req_cyc=%0d pushes=%0d dones=%0d, want -1 0 1",
                     first_req_cyc, got_ch.size(), done_cnt);
        else n_pass++;
    endtask

    task automatic test_fixed_ch();
        bit fin;
        do_start(16'h0800, 16'd20, 5'd0, 1'b0, 2'd3);
        wait_done(fin);
        n_checks++;
        if (!fin || got_ch.size() != exp_ch.size())
            $display("FAIL fixed_count: got fin=%0b n=%0d, want 1 %0d", fin, got_ch.size(), exp_ch.size());
        else n_pass++;
        foreach (exp_ch[i]) begin
            n_checks++;
            if (i >= got_ch.size() || got_ch[i] != exp_ch[i] || got_data[i] !== exp_data[i])
                $display("FAIL fixed_push[%0d]: got ch%0d %0h, want ch%0d %0h", i,
                         (i < got_ch.size()) ? got_ch[i] : -1,
                         (i < got_ch.size()) ? got_data[i] : 32'h0, exp_ch[i], exp_data[i]);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        bit fin;
        int viol;
        bit reached;
        ok_fixed = 4'b1101;
        do_start(16'h0200, 16'd40, 5'd16, 1'b1, 2'd0);
        reached = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (got_ch.size() >= 16) begin
                reached = 1;
                break;
            end
        end
        n_checks++;
        if (!reached) $display("FAIL bp_first_burst: got %0d pushes, want 16", got_ch.size());
        else n_pass++;
        viol = 0;
        repeat (10) begin
            @(negedge clk);
            if (mem_req !== 1'b0 || busy !== 1'b1) viol++;
        end
        n_checks++;
        if (viol != 0 || got_ch.size() != 16)
            $display("FAIL bp_hold: got %0d bad cycles %0d pushes, want 0 16", viol, got_ch.size());
        else n_pass++;
        @(posedge clk); #1;
        ok_fixed = 4'hF;
        wait_done(fin);
        n_checks++;
        if (!fin || got_ch.size() != exp_ch.size())
            $display("FAIL bp_count: got fin=%0b n=%0d, want 1 %0d", fin, got_ch.size(), exp_ch.size());
        else n_pass++;
        foreach (exp_ch[i]) begin
            n_checks++;
            if (i >= got_ch.size() || got_ch[i] != exp_ch[i] || got_data[i] !== exp_data[i])
                $display("FAIL bp_push[%0d]: got ch%0d %0h, want ch%0d %0h", i,
                         (i < got_ch.size()) ? got_ch[i] : -1,
                         (i < got_ch.size()) ? got_data[i] : 32'h0, exp_ch[i], exp_data[i]);
            else n_pass++;
        end
`ifdef FIFO_PRODUCER_MC_PERF_EN
        n_checks++;
        if (!(perf_wait_cyc >= 32'd10) || perf_bursts !== 16'(exp_bursts))
            $display("FAIL bp_perf: got wait=%0d bursts=%0d, want >=10 %0d",
                     perf_wait_cyc, perf_bursts, exp_bursts);
        else n_pass++;
`endif
    endtask

    task automatic test_wrap_slow();
        bit fin;
        gnt_mode = 1; lat_cfg = 3;
        do_start(16'hFFFE, 16'd4, 5'd16, 1'b1, 2'd0);
        wait_done(fin);
        n_checks++;
        if (!fin || gnt_addr.size() != 4)
            $display("FAIL wrap_grants: got fin=%0b n=%0d, want 1 4", fin, gnt_addr.size());
        else n_pass++;
        foreach (exp_addr[i]) begin
            n_checks++;
            if (i >= gnt_addr.size() || gnt_addr[i] !== exp_addr[i] ||
                i >= got_data.size() || got_data[i] !== exp_data[i] || got_ch[i] != exp_ch[i])
                $display("FAIL wrap_beat[%0d]: got addr %0h data %0h, want %0h %0h", i,
                         (i < gnt_addr.size()) ? gnt_addr[i] : 16'h0,
                         (i < got_data.size()) ? got_data[i] : 32'h0, exp_addr[i], exp_data[i]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        bit fin;
        bit reached;
        int viol;
        gnt_mode = 1; lat_cfg = 3;
        do_start(16'h0300, 16'd40, 5'd8, 1'b1, 2'd2);
        reached = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (got_ch.size() >= 3) begin
                reached = 1;
                break;
            end
        end
        n_checks++;
        if (!reached) $display("FAIL rstmid_progress: got %0d pushes, want >=3", got_ch.size());
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({mem_req, mem_addr, fifo_push, fifo_wdata, busy, done} !== '0)
            $display("FAIL rstmid_outputs: req=%0b addr=%0h push=%0h wdata=%0h busy=%0b done=%0b, want all 0",
                     mem_req, mem_addr, fifo_push, fifo_wdata, busy, done);
        else n_pass++;
        viol = 0;
        repeat (8) begin
            @(negedge clk);
            if (fifo_push !== 4'b0 || busy !== 1'b0 || mem_req !== 1'b0) viol++;
        end
        n_checks++;
        if (viol != 0) $display("FAIL rstmid_quiet: got %0d active cycles, want 0", viol);
        else n_pass++;
        gnt_mode = 0; lat_cfg = 1;
        do_start(16'h0400, 16'd20, 5'd5, 1'b1, 2'd1);
        wait_done(fin);
        n_checks++;
        if (!fin || got_ch.size() != exp_ch.size())
            $display("FAIL rstmid_count: got fin=%0b n=%0d, want 1 %0d", fin, got_ch.size(), exp_ch.size());
        else n_pass++;
        foreach (exp_ch[i]) begin
            n_checks++;
            if (i >= got_ch.size() || got_ch[i] != exp_ch[i] || got_data[i] !== exp_data[i])
                $display("FAIL rstmid_push[%0d]: got ch%0d %0h, want ch%0d %0h", i,
                         (i < got_ch.size()) ? got_ch[i] : -1,
                         (i < got_ch.size()) ? got_data[i] : 32'h0, exp_ch[i], exp_data[i]);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        bit fin;
        int bad;
        gnt_mode = 2; lat_cfg = 0; ok_rand = 1;
        for (int t = 0; t < 8; t++) begin
            do_start(16'($urandom), 16'($urandom_range(0, 60)), 5'($urandom_range(0, 31)),
                     1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
            wait_done(fin);
            n_checks++;
            if (!fin || done_cnt != 1 || got_ch.size() != exp_ch.size())
                $display("FAIL rand%0d_count: got fin=%0b dones=%0d n=%0d, want 1 1 %0d",
                         t, fin, done_cnt, got_ch.size(), exp_ch.size());
            else n_pass++;
            bad = 0;
            foreach (exp_ch[i]) begin
                if (i >= got_ch.size() || got_ch[i] != exp_ch[i] || got_data[i] !== exp_data[i] ||
                    i >= gnt_addr.size() || gnt_addr[i] !== exp_addr[i]) bad++;
            end
            n_checks++;
            if (bad != 0 || gnt_addr.size() != exp_addr.size())
                $display("FAIL rand%0d_stream: got %0d wrong beats, %0d grants, want 0 %0d",
                         t, bad, gnt_addr.size(), exp_addr.size());
            else n_pass++;
        end
        ok_rand = 0; ok_fixed = 4'hF;
    endtask

    initial begin
        test_reset();
        test_rr_basic();
        test_zero_len();
        test_fixed_ch();
        test_backpressure();
        test_wrap_slow();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fifo_producer_mc.md
Name: fifo_producer_mc

Overview:
Multi-channel burst producer. On a start pulse, reads total_len words from word-addressed on-chip memory starting at base_addr, in bursts of up to burst_len words, and pushes each burst into one of NUM_CH downstream FIFOs. Channel selection is either round-robin per burst or fixed. It is the parametrised successor of the single-channel fifo producer, sitting between the SRAM read port and the systolic-array input FIFOs.

Parameters:
DATA_W, 32, memory/FIFO word width
ADDR_W, 16, word address width
LEN_W, 16, width of total_len
NUM_CH, 4, number of destination FIFOs (>=1)
MAX_BURST, 16, maximum words per burst; BL_W = $clog2(MAX_BURST+1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle start pulse; sampled only in IDLE
base_addr  in  ADDR_W  first word address, latched on start
total_len  in  LEN_W  words to transfer, latched on start
burst_len  in  BL_W  words per burst, latched on start; 0 or >MAX_BURST means MAX_BURST
mode_rr  in  1  1 = round-robin channels starting at ch_sel; 0 = all bursts to ch_sel; latched
ch_sel  in  $clog2(NUM_CH) (min 1)  start/fixed channel, latched; values >=NUM_CH map to 0
mem_req  out  1  read request
mem_addr  out  ADDR_W  read address
mem_gnt  in  1  request accepted this cycle
mem_rvalid  in  1  read data valid, in request order
mem_rdata  in  DATA_W  read data
fifo_burst_ok  in  NUM_CH  per-channel: free entries >= MAX_BURST
fifo_push  out  NUM_CH  one-hot push strobe
fifo_wdata  out  DATA_W  push data
busy  out  1  high whenever not in IDLE
done  out  1  one-cycle completion pulse

Behaviour:
- Clock/reset: single clock clk; rst is synchronous and active-high. Reset: state IDLE; mem_req=0, mem_addr=0, fifo_push=0, fifo_wdata=0, busy=0, done=0; all counters 0. rst mid-transfer aborts immediately; mem_rvalid arriving after reset is ignored.
- One-hot FSM states: IDLE, WAIT, BURST, BURST_DONE, BURST_NDONE, DONE.
- IDLE: start latches all config. total_len==0 -> DONE; else -> WAIT. start outside IDLE is ignored.
- WAIT: cur_len = min(eff_burst, remaining). If fifo_burst_ok[cur_ch] -> BURST, else stay.
- BURST: mem_req=1 while issued<cur_len. On mem_gnt: mem_addr+1, issued+1. Address wraps modulo 2^ADDR_W. On each mem_rvalid, received+1. Next cycle: fifo_wdata<=mem_rdata and fifo_push<=onehot(cur_ch), giving 1-cycle registered push latency. When received reaches cur_len -> remaining -= cur_len; if remaining==0 -> BURST_DONE else -> BURST_NDONE.
- BURST_NDONE: one cycle; clear issued/received; if mode_rr, cur_ch = (cur_ch+1) mod NUM_CH -> WAIT.
- BURST_DONE: one cycle; the final push is emitted this cycle -> DONE.
- DONE: done=1 for exactly one cycle -> IDLE.
- mem_rvalid outside BURST is ignored. mem_gnt and mem_rvalid may coincide in the same cycle; both counters update.
- Timing with a zero-wait memory: start at t gives mem_req at t+2 (WAIT at t+1, BURST at t+2).

Optional Feature:
FIFO_PRODUCER_MC_PERF_EN:
- Defined: adds outputs perf_wait_cyc (32b, cycles spent in WAIT) and perf_bursts (16b, completed bursts). Both are cleared on start and on rst, saturate at max, and hold after DONE.
- Undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package fifo_producer_mc_pkg holds:
  - one-hot state enum fifo_producer_mc_state_t, with bit-index localparams IDLE_B..DONE_B
  - helper localparam for BL_W computation
- Sub-module fifo_producer_mc_burst_ctr (issued/received counters, cur_len compare, address increment) is natural. The top keeps the FSM and channel rotation.

Test Plan:
1. base=0x0100, total=40, burst=16, mode_rr=1, ch_sel=0, all ok, zero-wait memory:
   - pushes 16 to ch0 (0x100-0x10F), 16 to ch1, 8 to ch2 (0x120-0x127)
   - done pulses once; busy falls with done.
2. total=0, start: no mem_req; done pulses 2 cycles after start.
3. mode_rr=0, ch_sel=3, total=20, burst=0 (means 16): pushes 16 then 4, all to ch3.
4. fifo_burst_ok[1]=0 for 10 cycles after burst 1:
   - FSM holds WAIT, no mem_req
   - resumes when ok rises; with PERF_EN, perf_wait_cyc>=10.
5. base=0xFFFE, total=4, mem_gnt every other cycle, rvalid 3 cycles after gnt:
   - addresses FFFE, FFFF, 0000, 0001
   - data order preserved.
6. rst asserted mid-burst, with rvalid still pulsing after reset:
   - next cycle all outputs at reset values; no fifo_push
   - a fresh start runs correctly.
